popcnt_serial: RTL and testbench

- Sequencer that shares a single popcnt6 instance (ABSTRACT_MODEL=0) to count set bits in a WIDTH-bit word.
- Feeds the word through popcnt6 one 6-bit chunk per cycle and accumulates the partial counts.
- Valid/ready handshake on both sides.
- Sits between a word producer (e.g. a sample/correlation stage) and a consumer of Hamming weights, where area matters more than throughput.

---
 rtl/popcnt_serial.sv | 229 ++++++++++++++++++++++
 tb/tb_popcnt_serial.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/popcnt_serial.sv
// popcnt_serial: area-lean Hamming-weight engine. A single 6-bit popcount
// (popcnt6) is time-shared: the accepted word is held in a shift register and
// one 6-bit chunk per cycle is counted into an accumulator.
//
// Optional feature macro: POPCNT_SERIAL_THRESHOLD_EN
//   defined   -> o_ge = (final count >= i_threshold sampled at acceptance)
//   undefined -> o_ge tied to 0, i_threshold ignored
//
// Ports (popcnt_serial):
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_x          WIDTH-bit word to count
//   i_valid      i_x valid
//   o_ready      block can accept a word (IDLE only)
//   o_count      CNT_W-bit set-bit count of the accepted word
//   o_valid      o_count valid (DONE only)
//   i_ready      consumer accepts o_count
//   i_threshold  compare value (threshold feature only)
//   o_ge         o_count >= i_threshold (threshold feature only)
//
// Ports (popcnt6):
//   i_x          6-bit chunk
//   o_cnt        3-bit number of set bits

// 6-bit popcount; ABSTRACT_MODEL=1 is a behavioural loop, 0 a full-adder tree.
module popcnt6 #(
    parameter bit ABSTRACT_MODEL = 1'b0
) (
    input  logic [5:0] i_x,
    output logic [2:0] o_cnt
);

    generate
        if (ABSTRACT_MODEL) begin : g_abstract
            always_comb begin
                o_cnt = 3'd0;
                for (int i = 0; i < 6; i++) begin
                    o_cnt = o_cnt + 3'(i_x[i]);
                end
            end
        end else begin : g_adder_tree
            logic s_lo;
            logic c_lo;
            logic s_hi;
            logic c_hi;
            logic c_s;

            // Two 3:2 compressors, one per half of the chunk.
            assign s_lo = i_x[0] ^ i_x[1] ^ i_x[2];
            assign c_lo = (i_x[0] & i_x[1]) | (i_x[0] & i_x[2]) | (i_x[1] & i_x[2]);
            assign s_hi = i_x[3] ^ i_x[4] ^ i_x[5];
            assign c_hi = (i_x[3] & i_x[4]) | (i_x[3] & i_x[5]) | (i_x[4] & i_x[5]);

            // Sum bits add directly; the three weight-2 terms fold into bits 1/2.
            assign c_s = s_lo & s_hi;
            assign o_cnt[0] = s_lo ^ s_hi;
            assign o_cnt[1] = c_lo ^ c_hi ^ c_s;
            assign o_cnt[2] = (c_lo & c_hi) | (c_lo & c_s) | (c_hi & c_s);
        end
    endgenerate

endmodule

module popcnt_serial #(
    parameter  int unsigned WIDTH   = 32,
    localparam int unsigned N_CHUNK = (WIDTH + 5) / 6,
    localparam int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid,
    input  logic             i_ready,
    input  logic [CNT_W-1:0] i_threshold,
    output logic             o_ge
);

    localparam int unsigned SH_W  = N_CHUNK * 6;
    localparam int unsigned CTR_W = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [SH_W-1:0]    shreg_q;
    logic [SH_W-1:0]    shreg_d;
    logic [CTR_W-1:0]   chunk_q;
    logic [CTR_W-1:0]   chunk_d;
    logic [CNT_W-1:0]   acc_q;
    logic [CNT_W-1:0]   acc_d;
    logic               ready_q;
    logic               ready_d;
    logic               valid_q;
    logic               valid_d;
    logic               accept_c;
    logic               last_c;
    logic [2:0]         part_c;

    assign accept_c = (state_q == S_IDLE) && i_valid;
    assign last_c   = (chunk_q == CTR_W'(N_CHUNK - 1));

    // Shared popcount on the low chunk of the shift register.
    popcnt6 #(
        .ABSTRACT_MODEL (1'b0)
    ) u_popcnt6 (
        .i_x   (shreg_q[5:0]),
        .o_cnt (part_c)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_valid) state_d = S_BUSY;
            S_BUSY: if (last_c)  state_d = S_DONE;
            S_DONE: if (i_ready) state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the next state so they can be registered.
    always_comb begin
        ready_d = 1'b0;
        valid_d = 1'b0;
        case (state_d)
            S_IDLE:  ready_d = 1'b1;
            S_DONE:  valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Datapath: capture, shift and accumulate.
    always_comb begin
        shreg_d = shreg_q;
        chunk_d = chunk_q;
        acc_d   = acc_q;
        if (accept_c) begin
            shreg_d = SH_W'(i_x);
            chunk_d = '0;
            acc_d   = '0;
        end else if (state_q == S_BUSY) begin
            // Sum never exceeds WIDTH, so the narrowing cast cannot lose bits.
            acc_d   = acc_q + CNT_W'(part_c);
            shreg_d = shreg_q >> 6;
            chunk_d = chunk_q + CTR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shreg_q <= '0;
            chunk_q <= '0;
            acc_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            chunk_q <= chunk_d;
            acc_q   <= acc_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_count = acc_q;

`ifdef POPCNT_SERIAL_THRESHOLD_EN
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] thr_d;
    logic             ge_q;
    logic             ge_d;

    // Threshold is latched with the word; o_ge is set entering DONE, cleared leaving it.
    always_comb begin
        thr_d = thr_q;
        ge_d  = ge_q;
        if (accept_c) begin
            thr_d = i_threshold;
        end
        if ((state_q == S_BUSY) && (state_d == S_DONE)) begin
            ge_d = (acc_d >= thr_q);
        end else if ((state_q == S_DONE) && (state_d != S_DONE)) begin
            ge_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            thr_q <= '0;
            ge_q  <= 1'b0;
        end else begin
            thr_q <= thr_d;
            ge_q  <= ge_d;
        end
    end

    assign o_ge = ge_q;
`else
    logic unused_threshold;

    assign unused_threshold = ^i_threshold;
    assign o_ge             = 1'b0;
`endif

endmodule

// File: tb/tb_popcnt_serial.sv
// Testbench for popcnt_serial: a WIDTH=32 instance driven with directed and
// random words, plus a WIDTH=6 instance swept over all 64 inputs.
module tb_popcnt_serial;

    logic        clk;
    logic        rst_n;

    logic [31:0] x32;
    logic        vin32;
    logic        rdy32;
    logic [5:0]  cnt32;
    logic        vout32;
    logic        rin32;
    logic [5:0]  thr32;
    logic        ge32;

    logic [5:0]  x6;
    logic        vin6;
    logic        rdy6;
    logic [2:0]  cnt6;
    logic        vout6;
    logic        rin6;
    logic [2:0]  thr6;
    logic        ge6;

    int checks = 0;
    int errors = 0;

    popcnt_serial #(.WIDTH(32)) dut32 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_x         (x32),
        .i_valid     (vin32),
        .o_ready     (rdy32),
        .o_count     (cnt32),
        .o_valid     (vout32),
        .i_ready     (rin32),
        .i_threshold (thr32),
        .o_ge        (ge32)
    );

    popcnt_serial #(.WIDTH(6)) dut6 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_x         (x6),
        .i_valid     (vin6),
        .o_ready     (rdy6),
        .o_count     (cnt6),
        .o_valid     (vout6),
        .i_ready     (rin6),
        .i_threshold (thr6),
        .o_ge        (ge6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count set bits of the low w bits.
    function automatic int ref_pop(input logic [31:0] v, input int w);
        int s;
        s = 0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) s = s + 1;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the 32-bit instance, scrambling x/threshold after acceptance.
    task automatic run_word(input logic [31:0] x, input logic [5:0] thr, input string tag);
        int n;
        int exp_c;
        int exp_ge;
        exp_c = ref_pop(x, 32);
`ifdef POPCNT_SERIAL_THRESHOLD_EN
        exp_ge = (exp_c >= int'(thr)) ? 1 : 0;
`else
        exp_ge = 0;
`endif
        n = 0;
        while (!rdy32 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 32'(rdy32), 1);
        x32   = x;
        thr32 = thr;
        vin32 = 1'b1;
        tick();
        vin32 = 1'b0;
        x32   = $urandom;
        thr32 = 6'($urandom);
        n = 0;
        while (!vout32 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 6);
        chk({tag, "_count"}, 32'(cnt32), exp_c);
        chk({tag, "_ge"}, 32'(ge32), exp_ge);
        chk({tag, "_busy_ready"}, 32'(rdy32), 0);
        rin32 = 1'b1;
        tick();
        rin32 = 1'b0;
        chk({tag, "_release_valid"}, 32'(vout32), 0);
        chk({tag, "_release_ready"}, 32'(rdy32), 1);
        chk({tag, "_release_ge"}, 32'(ge32), 0);
    endtask

    initial begin
        logic [31:0] w;
        int          n;
        int          exp_c;

        rst_n = 1'b0;
        x32 = '0; vin32 = 1'b0; rin32 = 1'b0; thr32 = '0;
        x6  = '0; vin6  = 1'b0; rin6  = 1'b0; thr6  = '0;
        #12;
        chk("rst_ready", 32'(rdy32), 1);
        chk("rst_valid", 32'(vout32), 0);
        chk("rst_count", 32'(cnt32), 0);
        chk("rst_ge", 32'(ge32), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed words, including the 2-bit top chunk.
        run_word(32'h0000_0000, 6'd0,  "zero");
        run_word(32'hFFFF_FFFF, 6'd32, "ones");
        run_word(32'hAAAA_AAAA, 6'd17, "alt");
        run_word(32'hC000_0000, 6'd2,  "top");
        run_word(32'h0000_00FF, 6'd8,  "thr8");
        run_word(32'h0000_00FF, 6'd9,  "thr9");

        // Random words and thresholds.
        for (int i = 0; i < 20; i++) begin
            run_word($urandom, 6'($urandom_range(0, 33)), "rand");
        end

        // Backpressure: hold DONE for 10 cycles while the producer toggles.
        w = $urandom;
        exp_c = ref_pop(w, 32);
        x32 = w;
        vin32 = 1'b1;
        tick();
        vin32 = 1'b0;
        n = 0;
        while (!vout32 && n < 50) begin
            tick();
            n++;
        end
        chk("bp_latency", n, 6);
        for (int i = 0; i < 10; i++) begin
            x32   = $urandom;
            vin32 = 1'($urandom);
            tick();
            chk("bp_valid", 32'(vout32), 1);
            chk("bp_count", 32'(cnt32), exp_c);
            chk("bp_ready", 32'(rdy32), 0);
        end
        vin32 = 1'b0;
        rin32 = 1'b1;
        tick();
        rin32 = 1'b0;
        chk("bp_after_ready", 32'(rdy32), 1);
        chk("bp_after_valid", 32'(vout32), 0);

        // Reset during the third BUSY cycle.
        x32 = 32'hFFFF_FFFF;
        vin32 = 1'b1;
        tick();
        vin32 = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstbusy_ready", 32'(rdy32), 1);
        chk("rstbusy_valid", 32'(vout32), 0);
        chk("rstbusy_count", 32'(cnt32), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_word(32'h0000_000F, 6'd4, "post_rst");

        // Reset while a result is pending in DONE.
        x32 = 32'h1234_5678;
        vin32 = 1'b1;
        tick();
        vin32 = 1'b0;
        n = 0;
        while (!vout32 && n < 50) begin
            tick();
            n++;
        end
        chk("rstdone_reached", 32'(vout32), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstdone_valid", 32'(vout32), 0);
        chk("rstdone_ready", 32'(rdy32), 1);
        chk("rstdone_count", 32'(cnt32), 0);
        chk("rstdone_ge", 32'(ge32), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_word(32'h8000_0001, 6'd3, "post_rst2");

        // Exhaustive sweep of the 6-bit instance.
        for (int v = 0; v < 64; v++) begin
            chk("w6_ready", 32'(rdy6), 1);
            x6   = 6'(v);
            vin6 = 1'b1;
            tick();
            vin6 = 1'b0;
            x6   = 6'($urandom);
            tick();
            chk("w6_valid", 32'(vout6), 1);
            chk("w6_count", 32'(cnt6), ref_pop(32'(v), 6));
            rin6 = 1'b1;
            tick();
            rin6 = 1'b0;
        end
        chk("w6_ge_idle", 32'(ge6), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
